// File: rtl/spi_master_controller_if.sv
// Request/response and SPI pin bundle for the SPI master controller.
// The master modport is the controller's view; the slave modport is the requester plus attached SPI device.
interface spi_master_controller_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic [7:0]            req_cmd;
  logic                  req_has_addr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_dummy;
  logic                  req_rd;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  spi_csn;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_miso;

  modport master (
    input  req_valid, req_cmd, req_has_addr, req_addr, req_dummy, req_rd, req_wdata,
    output req_ready, rsp_valid, rsp_rdata,
    output spi_csn, spi_sclk, spi_mosi,
    input  spi_miso
  );

  modport slave (
    output req_valid, req_cmd, req_has_addr, req_addr, req_dummy, req_rd, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  spi_csn, spi_sclk, spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_master_controller.sv
// Mode-0 SPI master: command, optional address, dummy cycles and one read or write data word per request.
// SCLK half-periods are CLK_DIV sys_clk cycles; every SPI output is registered.
module spi_master_controller #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  spi_master_controller_if.master bus
);
  localparam int MAX_A   = (ADDR_WIDTH > 255) ? ADDR_WIDTH : 255;
  localparam int MAX_LEN = (DATA_WIDTH > MAX_A) ? DATA_WIDTH : MAX_A;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, CSHIGH} state_t;

  state_t                state_reg;
  logic [7:0]            cmd_sh_reg;
  logic [ADDR_WIDTH-1:0] addr_sh_reg;
  logic [DATA_WIDTH-1:0] data_sh_reg;
  logic                  has_addr_reg;
  logic [7:0]            dummy_reg;
  logic                  rd_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [DIV_W-1:0]      div_cnt_reg;
  logic                  csn_reg;
  logic                  sclk_reg;
  logic                  mosi_reg;
  logic                  ready_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;

  logic [7:0]            cmd_shift;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [DATA_WIDTH-1:0] data_shift;
  state_t                nxt_state;
  logic [CNT_W-1:0]      nxt_cnt;
  logic                  nxt_mosi;

  assign cmd_shift  = {cmd_sh_reg[6:0], 1'b0};
  assign addr_shift = addr_sh_reg << 1;
  assign data_shift = data_sh_reg << 1;

  // Entry values for the phase that follows the current one once its last bit completes.
  always_comb begin
    nxt_state = CSHIGH;
    nxt_cnt   = '0;
    nxt_mosi  = 1'b0;
    if ((state_reg == CMD) && has_addr_reg) begin
      nxt_state = ADDR;
      nxt_cnt   = CNT_W'(ADDR_WIDTH - 1);
      nxt_mosi  = addr_sh_reg[ADDR_WIDTH-1];
    end else if (((state_reg == CMD) || (state_reg == ADDR)) && (dummy_reg != 8'd0)) begin
      nxt_state = DUMMY;
      nxt_cnt   = CNT_W'(dummy_reg) - CNT_W'(1);
    end else if (state_reg != DATA) begin
      nxt_state = DATA;
      nxt_cnt   = CNT_W'(DATA_WIDTH - 1);
      nxt_mosi  = ~rd_reg & data_sh_reg[DATA_WIDTH-1];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg     <= IDLE;
      cmd_sh_reg    <= '0;
      addr_sh_reg   <= '0;
      data_sh_reg   <= '0;
      has_addr_reg  <= 1'b0;
      dummy_reg     <= '0;
      rd_reg        <= 1'b0;
      bit_cnt_reg   <= '0;
      div_cnt_reg   <= '0;
      csn_reg       <= 1'b1;
      sclk_reg      <= 1'b0;
      mosi_reg      <= 1'b0;
      ready_reg     <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req_valid && ready_reg) begin
            state_reg    <= CMD;
            cmd_sh_reg   <= bus.req_cmd;
            addr_sh_reg  <= bus.req_addr;
            data_sh_reg  <= bus.req_wdata;
            has_addr_reg <= bus.req_has_addr;
            dummy_reg    <= bus.req_dummy;
            rd_reg       <= bus.req_rd;
            bit_cnt_reg  <= CNT_W'(7);
            div_cnt_reg  <= '0;
            csn_reg      <= 1'b0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= bus.req_cmd[7];
            ready_reg    <= 1'b0;
          end
        end
        CSHIGH: begin
          if (div_cnt_reg == DIV_LAST) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            ready_reg   <= 1'b1;
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end
        end
        default: begin
          if (div_cnt_reg != DIV_LAST) begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
          end else begin
            div_cnt_reg <= '0;
            if (!sclk_reg) begin
              // Rising SCLK: the slave's bit has been stable for the whole low half.
              sclk_reg <= 1'b1;
              if ((state_reg == DATA) && rd_reg)
                data_sh_reg <= DATA_WIDTH'({data_sh_reg, bus.spi_miso});
            end else begin
              sclk_reg <= 1'b0;
              if (bit_cnt_reg != '0) begin
                bit_cnt_reg <= bit_cnt_reg - CNT_W'(1);
                case (state_reg)
                  CMD: begin
                    cmd_sh_reg <= cmd_shift;
                    mosi_reg   <= cmd_shift[7];
                  end
                  ADDR: begin
                    addr_sh_reg <= addr_shift;
                    mosi_reg    <= addr_shift[ADDR_WIDTH-1];
                  end
                  DATA: begin
                    if (!rd_reg) data_sh_reg <= data_shift;
                    mosi_reg <= ~rd_reg & data_shift[DATA_WIDTH-1];
                  end
                  default: mosi_reg <= 1'b0;
                endcase
              end else begin
                state_reg   <= nxt_state;
                bit_cnt_reg <= nxt_cnt;
                mosi_reg    <= nxt_mosi;
                if (state_reg == DATA) begin
                  csn_reg       <= 1'b1;
                  rsp_valid_reg <= 1'b1;
                  rsp_rdata_reg <= rd_reg ? data_sh_reg : '0;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready = ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.spi_csn   = csn_reg;
  assign bus.spi_sclk  = sclk_reg;
  assign bus.spi_mosi  = mosi_reg;
endmodule

// File: tb/tb_spi_master_controller.sv
// Bench for spi_master_controller: two instances (CLK_DIV=2 and CLK_DIV=1) share one stimulus path selected by sel.
// A pin-level monitor acts as the SPI slave and records the MOSI stream; expectations come from a bit-list model.
module tb_spi_master_controller;
  localparam int AW = 12;
  localparam int DW = 8;

  typedef struct {
    logic [7:0]    cmd;
    logic          ha;
    logic [AW-1:0] addr;
    logic [7:0]    dummy;
    logic          rd;
    logic [DW-1:0] wdata;
    logic [DW-1:0] sdata;
  } txn_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 sys_clk = ~sys_clk;

  spi_master_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
  spi_master_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();

  spi_master_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(2)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if_a));
  spi_master_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLK_DIV(1)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(if_b));

  logic          sel = 1'b0;
  int            cur_div = 2;
  logic          req_valid = 1'b0;
  logic [7:0]    req_cmd = '0;
  logic          req_has_addr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [7:0]    req_dummy = '0;
  logic          req_rd = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          spi_miso = 1'b0;

  assign if_a.req_valid = req_valid & ~sel;
  assign if_b.req_valid = req_valid & sel;
  assign if_a.req_cmd = req_cmd;           assign if_b.req_cmd = req_cmd;
  assign if_a.req_has_addr = req_has_addr; assign if_b.req_has_addr = req_has_addr;
  assign if_a.req_addr = req_addr;         assign if_b.req_addr = req_addr;
  assign if_a.req_dummy = req_dummy;       assign if_b.req_dummy = req_dummy;
  assign if_a.req_rd = req_rd;             assign if_b.req_rd = req_rd;
  assign if_a.req_wdata = req_wdata;       assign if_b.req_wdata = req_wdata;
  assign if_a.spi_miso = spi_miso;         assign if_b.spi_miso = spi_miso;

  logic          m_ready, m_rsp_valid, m_csn, m_sclk, m_mosi;
  logic [DW-1:0] m_rdata;
  assign m_ready     = sel ? if_b.req_ready : if_a.req_ready;
  assign m_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
  assign m_rdata     = sel ? if_b.rsp_rdata : if_a.rsp_rdata;
  assign m_csn       = sel ? if_b.spi_csn   : if_a.spi_csn;
  assign m_sclk      = sel ? if_b.spi_sclk  : if_a.spi_sclk;
  assign m_mosi      = sel ? if_b.spi_mosi  : if_a.spi_mosi;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor / slave state
  logic          exp_bits[$];
  logic          mon_bits[$];
  int            exp_n = 0;
  logic [DW-1:0] slave_rdata = '0;
  int            mon_csn_low = 0, mon_rsp = 0, mon_viol = 0, mon_gap = 0;
  logic [DW-1:0] mon_rdata = '0;
  logic          prev_csn = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;
  int            run_len = 0, hi_run = 0;

  always @(negedge sys_clk) begin : monitor
    int k;
    if (sys_rst) begin
      prev_csn = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0;
      run_len = 0; hi_run = 0;
    end else begin
      if (m_rsp_valid) begin
        mon_rsp++;
        mon_rdata = m_rdata;
      end
      if (!m_csn) begin
        mon_csn_low++;
        if (prev_csn) begin
          if (m_sclk) mon_viol++;
          mon_gap = hi_run;
          hi_run  = 0;
          run_len = 1;
        end else begin
          if (m_sclk == prev_sclk) run_len++;
          else begin
            if (run_len != cur_div) mon_viol++;
            run_len = 1;
          end
          // MOSI may only move where SCLK falls (start of a low half).
          if ((m_mosi != prev_mosi) && !(prev_sclk && !m_sclk)) mon_viol++;
          if (m_sclk && !prev_sclk) mon_bits.push_back(m_mosi);
        end
        k = mon_bits.size();
        if ((k >= exp_n - DW) && (k < exp_n)) spi_miso = slave_rdata[DW-1-(k-(exp_n-DW))];
        else spi_miso = 1'($urandom_range(0, 1));
      end else begin
        if (!prev_csn && (run_len != cur_div)) mon_viol++;
        if (m_sclk) mon_viol++;
        hi_run++;
      end
      prev_csn = m_csn; prev_sclk = m_sclk; prev_mosi = m_mosi;
    end
  end

  function automatic int add_exp(input txn_t t);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(t.cmd[i]);
    if (t.ha) for (int i = AW-1; i >= 0; i--) exp_bits.push_back(t.addr[i]);
    for (int i = 0; i < int'(t.dummy); i++) exp_bits.push_back(1'b0);
    for (int i = DW-1; i >= 0; i--) exp_bits.push_back(t.rd ? 1'b0 : t.wdata[i]);
    return 8 + (t.ha ? AW : 0) + int'(t.dummy) + DW;
  endfunction

  task automatic drive_req(input txn_t t);
    req_cmd = t.cmd; req_has_addr = t.ha; req_addr = t.addr;
    req_dummy = t.dummy; req_rd = t.rd; req_wdata = t.wdata;
  endtask

  task automatic clear_mon();
    mon_bits.delete();
    mon_csn_low = 0; mon_rsp = 0; mon_viol = 0;
  endtask

  // Called at posedge+1 with req_valid high; returns at posedge+1 after the accepting edge.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (m_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge sys_clk); #1;
    end
    if (ok) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic wait_rsp(input int count, input int limit);
    for (int c = 0; c < limit && mon_rsp < count; c++) @(posedge sys_clk);
    repeat (2*cur_div + 4) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_stream(input int n);
    int mm;
    mm = 0;
    for (int i = 0; i < mon_bits.size() && i < exp_bits.size(); i++)
      if (mon_bits[i] !== exp_bits[i]) mm++;
    check_val("nbits", mon_bits.size(), n);
    check_val("mosi_mismatch", mm, 0);
  endtask

  task automatic do_txn(input txn_t t);
    int n;
    bit ok;
    exp_bits.delete();
    n = add_exp(t);
    exp_n = n;
    slave_rdata = t.sdata;
    clear_mon();
    drive_req(t);
    req_valid = 1'b1;
    wait_accept(ok);
    req_valid = 1'b0;
    check_val("accept", ok, 1);
    wait_rsp(1, n*2*cur_div + 50);
    $display("txn div=%0d cmd=%02h ha=%0d addr=%03h dummy=%0d rd=%0d wdata=%02h N=%0d csn_low=%0d rdata=%02h",
             cur_div, t.cmd, t.ha, t.addr, t.dummy, t.rd, t.wdata, n, mon_csn_low, mon_rdata);
    check_val("csn_low", mon_csn_low, n*2*cur_div);
    check_stream(n);
    check_val("timing_viol", mon_viol, 0);
    check_val("rsp_pulses", mon_rsp, 1);
    check_val("rsp_rdata", mon_rdata, t.rd ? t.sdata : '0);
    check_val("rdata_hold", m_rdata, t.rd ? t.sdata : '0);
    check_val("ready_back", m_ready, 1);
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.cmd   = 8'($urandom);
    t.ha    = 1'($urandom_range(0, 1));
    t.addr  = AW'($urandom);
    t.dummy = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
    t.rd    = 1'($urandom_range(0, 1));
    t.wdata = DW'($urandom);
    t.sdata = DW'($urandom);
    return t;
  endfunction

  initial begin
    txn_t t, t2;
    bit ok;
    int n1, n2;

    repeat (3) @(posedge sys_clk);
    #1;
    check_val("rst_ready", m_ready, 1);
    check_val("rst_csn", m_csn, 1);
    check_val("rst_sclk", m_sclk, 0);
    check_val("rst_mosi", m_mosi, 0);
    check_val("rst_rsp_valid", m_rsp_valid, 0);
    check_val("rst_rdata", m_rdata, 0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    // Directed cases at CLK_DIV=2
    t = '{8'h02, 1'b1, 12'h123, 8'd0, 1'b0, 8'hA5, 8'h00};
    do_txn(t);
    t = '{8'h0B, 1'b1, 12'h0FF, 8'd7, 1'b1, 8'hFF, 8'h3C};
    do_txn(t);
    t = '{8'h05, 1'b0, 12'hABC, 8'd0, 1'b1, 8'h5A, 8'hC3};
    do_txn(t);
    t = '{8'h9F, 1'b1, 12'hFFF, 8'd255, 1'b1, 8'h00, 8'h81};
    do_txn(t);

    // Back-to-back with req_valid held high
    t  = '{8'h02, 1'b1, 12'h456, 8'd3, 1'b0, 8'h3E, 8'h00};
    t2 = '{8'hD8, 1'b0, 12'h000, 8'd0, 1'b0, 8'hC1, 8'h00};
    exp_bits.delete();
    n1 = add_exp(t);
    n2 = add_exp(t2);
    exp_n = 0;
    clear_mon();
    drive_req(t);
    req_valid = 1'b1;
    wait_accept(ok);
    check_val("b2b_accept1", ok, 1);
    drive_req(t2);
    wait_accept(ok);
    check_val("b2b_accept2", ok, 1);
    check_val("b2b_first_done", mon_rsp, 1);
    req_valid = 1'b0;
    wait_rsp(2, (n1 + n2)*2*cur_div + 100);
    $display("b2b div=%0d N1=%0d N2=%0d gap=%0d rsp=%0d", cur_div, n1, n2, mon_gap, mon_rsp);
    check_val("b2b_rsp_pulses", mon_rsp, 2);
    check_val("b2b_gap_ok", (mon_gap >= cur_div), 1);
    check_val("b2b_csn_low", mon_csn_low, (n1 + n2)*2*cur_div);
    check_stream(n1 + n2);
    check_val("b2b_timing_viol", mon_viol, 0);

    // Reset during the address phase, with SCLK high
    t = '{8'h03, 1'b1, 12'hA5A, 8'd4, 1'b1, 8'h00, 8'h77};
    exp_bits.delete();
    exp_n = add_exp(t);
    clear_mon();
    drive_req(t);
    req_valid = 1'b1;
    wait_accept(ok);
    req_valid = 1'b0;
    check_val("abort_accept", ok, 1);
    for (int c = 0; c < 2000 && mon_bits.size() < 19; c++) begin
      @(posedge sys_clk); #1;
    end
    check_val("abort_reached_bit", mon_bits.size(), 19);
    #2;
    sys_rst = 1'b1;
    #1;
    $display("reset mid-ADDR: csn=%0d sclk=%0d ready=%0d rsp_valid=%0d", m_csn, m_sclk, m_ready, m_rsp_valid);
    check_val("abort_csn", m_csn, 1);
    check_val("abort_sclk", m_sclk, 0);
    check_val("abort_ready", m_ready, 1);
    check_val("abort_mosi", m_mosi, 0);
    repeat (2) @(posedge sys_clk);
    #3;
    sys_rst = 1'b0;
    repeat (40) @(posedge sys_clk);
    #1;
    check_val("abort_no_rsp", mon_rsp, 0);
    check_val("abort_rdata_cleared", m_rdata, 0);
    t = '{8'h02, 1'b1, 12'h321, 8'd2, 1'b1, 8'h00, 8'h96};
    do_txn(t);

    // Randomized traffic at CLK_DIV=2
    for (int i = 0; i < 12; i++) begin
      t = rand_txn();
      do_txn(t);
    end

    // CLK_DIV=1 corner on the second instance
    sel = 1'b1;
    cur_div = 1;
    repeat (2) @(posedge sys_clk);
    #1;
    t = '{8'h02, 1'b1, 12'h123, 8'd0, 1'b0, 8'hA5, 8'h00};
    do_txn(t);
    t = '{8'h0B, 1'b1, 12'h0FF, 8'd7, 1'b1, 8'hFF, 8'h3C};
    do_txn(t);
    for (int i = 0; i < 6; i++) begin
      t = rand_txn();
      do_txn(t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/spi_master_controller.md
SPI_MASTER_CONTROLLER -- requirements
Module: spi_master_controller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12: address phase length in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: data phase length in bits.
REQ-003 SHALL have parameter CLK_DIV, default 2, legal range >=1: sys_clk cycles per SCLK half-period.
REQ-004 SHALL have port sys_clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port sys_rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1: transaction request.
REQ-007 SHALL have port req_ready, output, 1: controller idle and able to accept a request.
REQ-008 SHALL have port req_cmd, input, 8: command byte.
REQ-009 SHALL have port req_has_addr, input, 1: include the address phase.
REQ-010 SHALL have port req_addr, input, ADDR_WIDTH: address.
REQ-011 SHALL have port req_dummy, input, 8: number of dummy SCLK cycles; 0 skips the dummy phase.
REQ-012 SHALL have port req_rd, input, 1: 1 = read data phase, 0 = write data phase.
REQ-013 SHALL have port req_wdata, input, DATA_WIDTH: write data.
REQ-014 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port rsp_rdata, output, DATA_WIDTH: read data, held until the next completion.
REQ-016 SHALL have port spi_csn, output, 1: chip select, low = selected.
REQ-017 SHALL have port spi_sclk, output, 1: serial clock, idles low (mode 0).
REQ-018 SHALL have port spi_mosi, output, 1: serial data to slave.
REQ-019 SHALL have port spi_miso, input, 1: serial data from slave.

Function
REQ-020 SHALL accept a request on the sys_clk edge where req_valid=1 and req_ready=1, and SHALL register all req_* fields at that edge.
REQ-021 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, CSHIGH; IDLE->CMD on accept; CMD->ADDR if has_addr, else ->DUMMY if dummy!=0, else ->DATA; ADDR->DUMMY if dummy!=0, else ->DATA; DUMMY->DATA; DATA->CSHIGH; CSHIGH->IDLE.
REQ-022 SHALL drive spi_csn low starting the cycle after accept and hold it low for exactly N*2*CLK_DIV cycles, where N = 8 + (has_addr ? ADDR_WIDTH : 0) + dummy + DATA_WIDTH.
REQ-023 For each bit, SHALL drive spi_sclk low for CLK_DIV cycles and then high for CLK_DIV cycles; the first low half-period begins with the spi_csn falling edge.
REQ-024 SHALL shift every field MSB first: cmd[7:0], then addr[ADDR_WIDTH-1:0], then wdata.
REQ-025 SHALL change spi_mosi only at the start of a low half-period, so each bit is stable for CLK_DIV cycles before the SCLK rising edge.
REQ-026 SHALL drive spi_mosi to 0 during DUMMY and during a read DATA phase.
REQ-027 During a read DATA phase, SHALL sample spi_miso on the sys_clk edge that raises spi_sclk and shift it in MSB first.
REQ-028 SHALL pulse rsp_valid for one cycle on the cycle spi_csn returns high.
REQ-029 SHALL update rsp_rdata with the sampled read data at completion of a read; for a write it SHALL be set to 0.
REQ-030 SHALL keep spi_csn high for CLK_DIV cycles (CSHIGH) before req_ready reasserts.
REQ-031 SHALL hold req_ready low from accept until CSHIGH ends, and SHALL ignore req_valid while not ready.
REQ-032 SHALL keep internal bit counters wide enough for max(ADDR_WIDTH, DATA_WIDTH, 255) with no wrap within a phase.

Reset
REQ-033 While sys_rst=1, SHALL force: state IDLE, spi_csn=1, spi_sclk=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0, req_ready=1.
REQ-034 Reset asserted mid-transaction SHALL take effect asynchronously and SHALL abandon the transaction with no rsp_valid pulse.

Verification
REQ-035 Write, CLK_DIV=2, cmd=0x02, has_addr=1, addr=0x123, dummy=0, wdata=0xA5 -> N=28, spi_csn low for 112 cycles, MOSI bit stream 00000010_000100100011_10100101, rsp_valid pulse, rsp_rdata=0x00.
REQ-036 Read, cmd=0x0B, has_addr=1, addr=0x0FF, dummy=7, slave model returns 0x3C on MISO -> N=35, MOSI=0 during dummy/data, rsp_rdata=0x3C.
REQ-037 No-address read, cmd=0x05, has_addr=0, dummy=0 -> N=16, no address bits appear on MOSI, transaction length 64 cycles at CLK_DIV=2.
REQ-038 req_valid held high across two requests -> second accept occurs only after CSHIGH; spi_csn high for >=CLK_DIV cycles between transactions; exactly two rsp_valid pulses.
REQ-039 sys_rst asserted at bit 10 of the ADDR phase -> immediately spi_csn=1, spi_sclk=0, req_ready=1, no rsp_valid; a following request completes normally.
REQ-040 CLK_DIV=1 corner -> SCLK period = 2 sys_clk cycles, all REQ-035 values hold with spi_csn low for 56 cycles.
